// File: rtl/input_pkg.sv
// Shared constants and the direction-resolve helper for the input conditioner.
package input_pkg;

  // Bit positions inside one player's controller_inputs slice
  localparam int IDX_CENTER = 0;
  localparam int IDX_LEFT   = 1;
  localparam int IDX_RIGHT  = 2;
  localparam int IDX_UP     = 3;
  localparam int IDX_DOWN   = 4;
  localparam int IDX_ATTACK = 5;
  localparam int IDX_SHIELD = 6;

  localparam int BTNS_PER_PLAYER = 6;
  localparam int SLICE_W         = 7;

  // Button order inside one player's group of debouncers
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_SHIELD = 5;

  typedef logic [SLICE_W-1:0] slice_t;

  // Turns debounced direction levels into the one-hot movement code
  // (bit 0 center). With socd_cancel set, opposing pairs cancel before
  // the left > right > up > down priority is applied.
  function automatic logic [4:0] resolve_dir(input logic left,
                                             input logic right,
                                             input logic up,
                                             input logic down,
                                             input logic socd_cancel);
    logic l, r, u, d;
    logic [4:0] onehot;
    l = left;
    r = right;
    u = up;
    d = down;
    if (socd_cancel) begin
      if (left && right) begin
        l = 1'b0;
        r = 1'b0;
      end
      if (up && down) begin
        u = 1'b0;
        d = 1'b0;
      end
    end
    onehot = 5'b00001;
    if (l)      onehot = 5'b00010;
    else if (r) onehot = 5'b00100;
    else if (u) onehot = 5'b01000;
    else if (d) onehot = 5'b10000;
    return onehot;
  endfunction

endpackage

// File: rtl/input_conditioner_btn_debounce.sv
// One button: two-flop synchroniser followed by a run-length debouncer.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES
// consecutive synchronised cycles; any agreeing cycle restarts the run.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count the current mismatch run; accept the new level on its last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      stable_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/input_conditioner.sv
// Multi-player controller front end: debounces every pin, resolves the
// direction pins into a one-hot code and registers the per-player slice
// together with press and change strobes.
module input_conditioner
  import input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SOCD_MODE       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4*NUM_PLAYERS-1:0]     dir_l,
  input  logic [NUM_PLAYERS-1:0]       attack,
  input  logic [NUM_PLAYERS-1:0]       shield,
  output logic [7*NUM_PLAYERS-1:0]     controller_inputs,
  output logic [NUM_PLAYERS-1:0]       attack_press,
  output logic [NUM_PLAYERS-1:0]       shield_press,
  output logic [NUM_PLAYERS-1:0]       changed
);

  localparam int  NUM_BTNS    = BTNS_PER_PLAYER * NUM_PLAYERS;
  localparam logic SOCD_CANCEL = (SOCD_MODE != 0);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] stable_btn;

  genvar gi;

  // Gather every player's pins as active-high button levels
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_raw
      assign raw_btn[gi*BTNS_PER_PLAYER +: 4]         = ~dir_l[gi*4 +: 4];
      assign raw_btn[gi*BTNS_PER_PLAYER + BTN_ATTACK] = attack[gi];
      assign raw_btn[gi*BTNS_PER_PLAYER + BTN_SHIELD] = shield[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw_btn[gi]),
        .stable (stable_btn[gi])
      );
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      logic [BTNS_PER_PLAYER-1:0] btn_s;
      slice_t                     slice_next;
      slice_t                     slice_reg;
      logic                       attack_d_reg;
      logic                       shield_d_reg;
      logic                       attack_press_reg;
      logic                       shield_press_reg;
      logic                       changed_reg;

      assign btn_s = stable_btn[gi*BTNS_PER_PLAYER +: BTNS_PER_PLAYER];

      assign slice_next = {btn_s[BTN_SHIELD], btn_s[BTN_ATTACK],
                           resolve_dir(btn_s[BTN_LEFT], btn_s[BTN_RIGHT],
                                       btn_s[BTN_UP], btn_s[BTN_DOWN],
                                       SOCD_CANCEL)};

      // Register the slice and derive edge/change strobes from the previous values
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slice_reg        <= SLICE_W'(1);
          attack_d_reg     <= 1'b0;
          shield_d_reg     <= 1'b0;
          attack_press_reg <= 1'b0;
          shield_press_reg <= 1'b0;
          changed_reg      <= 1'b0;
        end else begin
          slice_reg        <= slice_next;
          changed_reg      <= (slice_next != slice_reg);
          attack_press_reg <= btn_s[BTN_ATTACK] & ~attack_d_reg;
          shield_press_reg <= btn_s[BTN_SHIELD] & ~shield_d_reg;
          attack_d_reg     <= btn_s[BTN_ATTACK];
          shield_d_reg     <= btn_s[BTN_SHIELD];
        end
      end

      assign controller_inputs[gi*SLICE_W +: SLICE_W] = slice_reg;
      assign attack_press[gi] = attack_press_reg;
      assign shield_press[gi] = shield_press_reg;
      assign changed[gi]      = changed_reg;
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: three conditioner instances share one stimulus stream
// (strict SOCD / cancelling SOCD / single-cycle debounce). A reference
// model predicts every slice update; a monitor pops and compares them.
module tb_input_conditioner;
  import input_pkg::*;

  localparam int NP = 2;
  localparam int NI = 3;
  localparam int NB = 6 * NP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4*NP-1:0] dir_l = '1;
  logic [NP-1:0]   attack = '0;
  logic [NP-1:0]   shield = '0;

  logic [7*NP-1:0] ci [NI];
  logic [NP-1:0]   ap [NI];
  logic [NP-1:0]   sp [NI];
  logic [NP-1:0]   ch [NI];

  always #5 clk = ~clk;

  input_conditioner #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(4), .SOCD_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dir_l(dir_l), .attack(attack), .shield(shield),
    .controller_inputs(ci[0]), .attack_press(ap[0]), .shield_press(sp[0]), .changed(ch[0]));
  input_conditioner #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(4), .SOCD_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dir_l(dir_l), .attack(attack), .shield(shield),
    .controller_inputs(ci[1]), .attack_press(ap[1]), .shield_press(sp[1]), .changed(ch[1]));
  input_conditioner #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(1), .SOCD_MODE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .dir_l(dir_l), .attack(attack), .shield(shield),
    .controller_inputs(ci[2]), .attack_press(ap[2]), .shield_press(sp[2]), .changed(ch[2]));

  typedef struct packed {
    int         cyc;
    logic [6:0] slice;
    logic       ap;
    logic       sp;
  } exp_t;

  exp_t sb_q [NI*NP][$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic       stable_m [NI][NB];
  int         run_m    [NI][NB];
  logic       hist1    [NB];
  logic       hist2    [NB];
  logic [6:0] out_m    [NI][NP];

  logic [4*NP-1:0] cur_dir = '1;
  logic [NP-1:0]   cur_att = '0;
  logic [NP-1:0]   cur_sh  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dcfg(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic logic socd_cfg(input int i);
    return (i == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic raw_bit(input int b);
    int p;
    int lb;
    p  = b / 6;
    lb = b % 6;
    if (lb < 4)       return ~dir_l[4*p + lb];
    else if (lb == 4) return attack[p];
    else              return shield[p];
  endfunction

  // Expected slice from the model's accepted levels
  function automatic logic [6:0] model_slice(input int i, input int p);
    logic [3:0] pr;
    logic [4:0] mv;
    int first;
    pr[0] = stable_m[i][6*p+0];
    pr[1] = stable_m[i][6*p+1];
    pr[2] = stable_m[i][6*p+2];
    pr[3] = stable_m[i][6*p+3];
    if (socd_cfg(i) && pr[0] && pr[1]) pr[1:0] = 2'b00;
    if (socd_cfg(i) && pr[2] && pr[3]) pr[3:2] = 2'b00;
    first = -1;
    for (int k = 0; k < 4; k++) if (pr[k] && first < 0) first = k;
    mv = (first < 0) ? 5'd1 : 5'(1 << (first + 1));
    return {stable_m[i][6*p+5], stable_m[i][6*p+4], mv};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int b = 0; b < NB; b++) begin
        stable_m[i][b] = 1'b0;
        run_m[i][b]    = 0;
      end
      for (int p = 0; p < NP; p++) out_m[i][p] = 7'b0000001;
    end
    for (int b = 0; b < NB; b++) begin
      hist1[b] = 1'b0;
      hist2[b] = 1'b0;
    end
  endtask

  // Predict the effect of the coming clock edge
  task automatic model_edge();
    exp_t e;
    logic [6:0] ns;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < NP; p++) begin
        ns = model_slice(i, p);
        if (ns != out_m[i][p]) begin
          e.cyc   = cyc + 1;
          e.slice = ns;
          e.ap    = ns[IDX_ATTACK] & ~out_m[i][p][IDX_ATTACK];
          e.sp    = ns[IDX_SHIELD] & ~out_m[i][p][IDX_SHIELD];
          sb_q[i*NP+p].push_back(e);
        end
        out_m[i][p] = ns;
      end
      for (int b = 0; b < NB; b++) begin
        if (hist2[b] != stable_m[i][b]) begin
          run_m[i][b]++;
          if (run_m[i][b] == dcfg(i)) begin
            stable_m[i][b] = hist2[b];
            run_m[i][b]    = 0;
          end
        end else begin
          run_m[i][b] = 0;
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      hist2[b] = hist1[b];
      hist1[b] = raw_bit(b);
    end
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < NP; p++)
        check($sformatf("reset_slice i%0d p%0d", i, p), 32'(ci[i][7*p +: 7]), 32'h01);
      check($sformatf("reset_strobes i%0d", i), {26'd0, ap[i], sp[i], ch[i]}, 32'd0);
    end
  endtask

  task automatic step(input logic rst_v);
    @(negedge clk);
    #1;
    rst_n  = rst_v;
    dir_l  = cur_dir;
    attack = cur_att;
    shield = cur_sh;
    if (!rst_v) begin
      model_reset();
      #1;
      check_reset_state();
    end else begin
      model_edge();
    end
  endtask

  task automatic idle(input int n);
    cur_dir = '1;
    cur_att = '0;
    cur_sh  = '0;
    repeat (n) step(1'b1);
  endtask

  // Monitor: every strobe must match the next predicted update of that player
  initial begin
    exp_t e;
    int q;
    logic ev;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < NP; p++) begin
          q  = i*NP + p;
          ev = ch[i][p] | ap[i][p] | sp[i][p];
          if (ev) begin
            if (sb_q[q].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_event i%0d p%0d: got slice %0h ch%0b ap%0b sp%0b, required no event (cycle %0d)",
                       i, p, ci[i][7*p +: 7], ch[i][p], ap[i][p], sp[i][p], cyc);
            end else begin
              e = sb_q[q].pop_front();
              check($sformatf("event_cycle i%0d p%0d", i, p), 32'(cyc), 32'(e.cyc));
              check($sformatf("slice i%0d p%0d", i, p), 32'(ci[i][7*p +: 7]), 32'(e.slice));
              check($sformatf("strobes{ch,ap,sp} i%0d p%0d", i, p),
                    {29'd0, ch[i][p], ap[i][p], sp[i][p]}, {29'd0, 1'b1, e.ap, e.sp});
            end
          end else if (sb_q[q].size() != 0 && sb_q[q][0].cyc <= cyc) begin
            e = sb_q[q].pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event i%0d p%0d: got no strobe, required slice %0h at cycle %0d (now %0d)",
                     i, p, e.slice, e.cyc, cyc);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomised bouncing pins
  initial begin
    int rate;
    model_reset();
    // reset with arbitrary pins
    cur_dir = 8'h5A;
    cur_att = 2'b11;
    cur_sh  = 2'b01;
    repeat (3) step(1'b0);
    idle(5);
    // clean press: player 0 left
    cur_dir[0] = 1'b0;
    repeat (10) step(1'b1);
    idle(10);
    // SOCD: left+right, then add up
    cur_dir[1:0] = 2'b00;
    repeat (12) step(1'b1);
    cur_dir[2] = 1'b0;
    repeat (12) step(1'b1);
    idle(12);
    // bounce rejection then long hold on player 1 attack
    cur_att[1] = 1'b1;
    repeat (3) step(1'b1);
    idle(10);
    cur_att[1] = 1'b1;
    repeat (104) step(1'b1);
    idle(10);
    // bounce restart on player 0 attack
    cur_att[0] = 1'b1;
    repeat (3) step(1'b1);
    cur_att[0] = 1'b0;
    step(1'b1);
    cur_att[0] = 1'b1;
    repeat (10) step(1'b1);
    idle(10);
    // reset mid-debounce with shield held throughout
    cur_sh[0] = 1'b1;
    repeat (2) step(1'b1);
    repeat (2) step(1'b0);
    repeat (10) step(1'b1);
    idle(10);
    // randomised bouncing on all pins, occasional resets
    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(2, 0))
        0:       rate = 2;
        1:       rate = 8;
        default: rate = 32;
      endcase
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < 4*NP; b++)
          if ($urandom_range(rate-1, 0) == 0) cur_dir[b] = ~cur_dir[b];
        for (int p = 0; p < NP; p++) begin
          if ($urandom_range(rate-1, 0) == 0) cur_att[p] = ~cur_att[p];
          if ($urandom_range(rate-1, 0) == 0) cur_sh[p]  = ~cur_sh[p];
        end
        if ($urandom_range(399, 0) == 0) repeat (2) step(1'b0);
        else step(1'b1);
      end
    end
    idle(20);
    for (int q = 0; q < NI*NP; q++)
      check($sformatf("queue_drained %0d", q), 32'(sb_q[q].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-player input front end. It replaces the single-player, unfiltered controller decoder. For each of NUM_PLAYERS breadboard controllers it synchronises the raw pins, debounces every button, and resolves the direction pins into a one-hot movement code using a selectable SOCD mode. It also emits single-cycle press strobes for attack and shield. It sits between the board pins and the game-logic/player-state blocks, and all outputs are registered.

## Interface
- NUM_PLAYERS, 2: number of independent controllers (≥1).
- DEBOUNCE_CYCLES, 250000: consecutive synchronised cycles a new level must hold before it is accepted (≥1); 2.5 ms at 100 MHz.
- SOCD_MODE, 0: 0 = strict priority; 1 = opposing directions cancel before priority.
- clk  in  1  system clock; the one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- dir_l  in  4*NUM_PLAYERS  raw direction pins, active-low. Per player p, slice [4p+3:4p] = {down_l, up_l, right_l, left_l}.
- attack  in  NUM_PLAYERS  raw attack buttons, active-high.
- shield  in  NUM_PLAYERS  raw shield buttons, active-high.
- controller_inputs  out  7*NUM_PLAYERS  per-player slice [7p+6:7p], active-high: bit0 center, bit1 left, bit2 right, bit3 up, bit4 down, bit5 attack held, bit6 shield held. Bits 0–4 are always exactly one-hot.
- attack_press  out  NUM_PLAYERS  1-cycle strobe on the debounced attack rising edge.
- shield_press  out  NUM_PLAYERS  1-cycle strobe on the debounced shield rising edge.
- changed  out  NUM_PLAYERS  1-cycle strobe whenever that player's controller_inputs slice changes value.

## Operation
- Each of the 6*NUM_PLAYERS buttons has the same three stages:
  - **Synchroniser:** 2-flop synchroniser, sync1 then sync2.
  - **Debounce counter:** cnt has width clog2(DEBOUNCE_CYCLES+1). cnt clears whenever sync2 == stable. While sync2 != stable, cnt increments every cycle.
  - **Stable update:** when sync2 != stable and cnt == DEBOUNCE_CYCLES-1, stable takes sync2 and cnt clears on the same edge. A mismatch run shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged. cnt never wraps.
- Direction pins are inverted to active-high before debounce, so stable = 1 means pressed.
- **Direction resolve** (combinational, on stable values):
  - SOCD_MODE=1 only: if L&R, both are treated as released; if U&D, both are treated as released.
  - Priority is left > right > up > down. If none remain pressed, the code is center.
- **Output register**, per player, every cycle:
  - controller_inputs slice ← {shield_s, attack_s, onehot[4:0]}.
  - attack_press ← attack_s & ~attack_s_d, where attack_s_d is the stable value from the previous cycle. shield_press is formed the same way.
  - changed ← (new slice != current slice).
- Attack and shield are independent of each other and of direction.
- Players are fully independent; there is no cross-player interaction.

## Timing
- **Reset** (asynchronous assert; release synchronous to clk):
  - sync flops and stable take the released level (0 after inversion).
  - cnt = 0.
  - Each controller_inputs slice = 7'b0000001.
  - attack_press = shield_press = changed = 0.
- **Latency:** a raw level first sampled at edge k reaches stable at edge k+DEBOUNCE_CYCLES+1 and the outputs at edge k+DEBOUNCE_CYCLES+2.
- **Strobe timing:** attack_press, shield_press and changed assert on the same edge as the controller_inputs update, for exactly one cycle.
- **Holding a button** produces no repeated press strobes.
- **Glitch mid-count:** any single cycle of sync2 == stable restarts the count from 0.
- **Reset mid-debounce:** the partial count is discarded. After reset, the outputs are center, with nothing held.
- **Simultaneous events:** changes on different buttons debounce independently and may land on the same edge. One combined slice update then occurs, with a single changed pulse.

## Structure
- **Package `input_pkg`:** holds the bit-index constants IDX_CENTER=0, IDX_LEFT=1, IDX_RIGHT=2, IDX_UP=3, IDX_DOWN=4, IDX_ATTACK=5, IDX_SHIELD=6, plus BTNS_PER_PLAYER=6 and SLICE_W=7.
- **Sub-module `btn_debounce`:** parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw (active-high), stable. It contains the synchroniser, counter and stable flop.
- **Top level:** generate loops instantiate btn_debounce 6*NUM_PLAYERS times, then the per-player resolve logic and output register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless stated.
- **Reset:** rst_n=0 with arbitrary pins → every slice 7'b0000001 and all strobes 0; release with pins idle → outputs unchanged.
- **Clean press:** drive left_l of player 0 low at edge k and hold → slice0 = 7'b0000010 at edge k+6, changed[0]=1 for one cycle. Player 1 slice stays 7'b0000001.
- **Bounce rejection:** attack[1] high for 3 cycles then low → no change, no strobe. Held for 4 cycles → bit5 set, attack_press[1] pulses once. Held for 100 more cycles → no further pulse.
- **Bounce restart:** attack high for 3 cycles, low for 1, then high and held → the count restarts after the low cycle, and acceptance lands 4 cycles after the restart.
- **SOCD:** left_l and right_l both low.
  - SOCD_MODE=0 → 7'b0000010 (left).
  - SOCD_MODE=1 → 7'b0000001 (center).
  - SOCD_MODE=1 with up_l also low → 7'b0001000 (up).
- **Reset mid-debounce:** press shield, assert rst_n after 2 cycles, release reset with shield still held → shield accepted 6 edges after release, shield_press pulses once. Also run with DEBOUNCE_CYCLES=1 → latency 3 edges.
